// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops one byte per frame from a synchronous FIFO read port and
// serialises it as an 8N1 UART frame (start, LSB-first data, stop) on tx.
module fifo_uart_tx #(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int BAUD        = 115200,
   parameter int DATA_BITS   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_en,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic [DATA_BITS-1:0] fifo_dout,
   output logic                 tx,
   output logic                 busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_baud
         $error("fifo_uart_tx: CLK_FREQ_HZ / BAUD must be at least 2");
      end
      if (DATA_BITS < 2) begin : g_bad_width
         $error("fifo_uart_tx: DATA_BITS must be at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      STOP
   } state_t;

   state_t               state_reg;
   logic [CW-1:0]        baud_cnt_reg;
   logic [BW-1:0]        bit_idx_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 tx_reg;
   logic                 busy_reg;
   logic                 baud_done;

   // Pops only from IDLE, so each frame consumes exactly one FIFO entry.
   assign fifo_rd_en = (state_reg == IDLE) && tx_en && !fifo_empty && !rst;
   assign baud_done  = (baud_cnt_reg == BAUD_LAST);
   assign tx         = tx_reg;
   assign busy       = busy_reg;

   // tx is driven from the next state so it changes on the same edge as the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
         busy_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               tx_reg       <= 1'b1;
               busy_reg     <= 1'b0;
               baud_cnt_reg <= '0;
               if (fifo_rd_en) begin
                  state_reg <= LOAD;
                  busy_reg  <= 1'b1;
               end
            end
            LOAD: begin
               shift_reg    <= fifo_dout;
               baud_cnt_reg <= '0;
               bit_idx_reg  <= '0;
               tx_reg       <= 1'b0;
               state_reg    <= START;
            end
            START: begin
               if (baud_done) begin
                  baud_cnt_reg <= '0;
                  bit_idx_reg  <= '0;
                  tx_reg       <= shift_reg[0];
                  state_reg    <= DATA;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + CW'(1);
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_cnt_reg <= '0;
                  if (bit_idx_reg == BIT_LAST) begin
                     tx_reg    <= 1'b1;
                     state_reg <= STOP;
                  end else begin
                     shift_reg   <= shift_reg >> 1;
                     tx_reg      <= shift_reg[1];
                     bit_idx_reg <= bit_idx_reg + BW'(1);
                  end
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + CW'(1);
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud_cnt_reg <= '0;
                  busy_reg     <= 1'b0;
                  tx_reg       <= 1'b1;
                  state_reg    <= IDLE;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + CW'(1);
               end
            end
            default: begin
               tx_reg    <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a small synchronous FIFO feeds the transmitter and
// frames are decoded on tx at bit centres against hand-written bit patterns.
module tb_fifo_uart_tx;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // bit k = tx sample at centre of bit k (0=start, 9=stop)
   } vec_t;

   vec_t vecs [0:14];

   logic       clk = 1'b0;
   logic       rst;
   logic       fifo_rst;
   logic       tx_en;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       fifo_empty;
   logic       fifo_full;
   logic       fifo_rd_en;
   logic [7:0] fifo_dout;
   logic       tx;
   logic       busy;

   int errors = 0;
   int checks = 0;
   int rd_pulses = 0;
   int busy_cycles = 0;

   always #5 clk = ~clk;

   fifo_uart_tx #(
      .CLK_FREQ_HZ(1000),
      .BAUD(100),
      .DATA_BITS(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tx_en(tx_en),
      .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en),
      .fifo_dout(fifo_dout),
      .tx(tx),
      .busy(busy)
   );

   // Synchronous FIFO, DEPTH_POW_2=3: 7 usable entries, registered read data.
   logic [7:0] fifo_mem [0:7];
   logic [2:0] wptr;
   logic [2:0] rptr;
   int         fifo_count;

   assign fifo_empty = (fifo_count == 0);
   assign fifo_full  = (fifo_count == 7);

   always @(posedge clk) begin
      if (fifo_rst) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= 0;
         fifo_dout  <= '0;
      end else begin
         if (wr_en && !fifo_full) begin
            fifo_mem[wptr] <= wr_data;
            wptr           <= wptr + 3'd1;
         end
         if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= fifo_mem[rptr];
            rptr      <= rptr + 3'd1;
         end
         fifo_count <= fifo_count + ((wr_en && !fifo_full) ? 1 : 0)
                                  - ((fifo_rd_en && !fifo_empty) ? 1 : 0);
      end
   end

   // Counted on the edge the DUT samples them.
   always @(posedge clk) begin
      if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   // Waits (bounded) for the start bit, then samples every bit centre.
   // Returns at the centre of the stop bit.
   task automatic decode_frame(output logic [9:0] bits, output int waited, output bit ok);
      bits   = '0;
      waited = 0;
      while (tx !== 1'b0 && waited < 2000) begin
         step();
         waited++;
      end
      ok = (tx === 1'b0);
      if (ok) begin
         repeat (5) step();
         bits[0] = tx;
         for (int k = 1; k < 10; k++) begin
            repeat (10) step();
            bits[k] = tx;
         end
      end
   endtask

   task automatic check_frame(input string name, input int idx, input logic [9:0] bits, input bit ok);
      check({name, "_started"}, 32'(ok), 32'd1);
      check(name, 32'(bits), 32'(vecs[idx].frame));
      $display("frame %s: data=%02h bits=%010b", name, vecs[idx].data, bits);
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 50 && busy !== 1'b0; c++) step();
      check("idle_reached", 32'(busy), 32'd0);
   endtask

   task automatic run_burst(input string name, input int first, input int n, input bit check_full);
      int         rd0;
      int         waited;
      bit         ok;
      logic [9:0] bits;
      tx_en = 1'b0;
      for (int i = 0; i < n; i++) push(vecs[first + i].data);
      if (check_full) check({name, "_full"}, 32'(fifo_full), 32'd1);
      rd0   = rd_pulses;
      tx_en = 1'b1;
      if (check_full) begin
         step();
         check({name, "_full_clears"}, 32'(fifo_full), 32'd0);
      end
      for (int i = 0; i < n; i++) begin
         decode_frame(bits, waited, ok);
         check_frame($sformatf("%s_%0d", name, i), first + i, bits, ok);
         // From stop centre: 4 stop cycles + IDLE + LOAD, then start on the 7th step.
         if (i > 0) check($sformatf("%s_gap_%0d", name, i), 32'(waited), 32'd7);
      end
      wait_idle();
      check({name, "_pops"}, 32'(rd_pulses - rd0), 32'(n));
      check({name, "_empty"}, 32'(fifo_empty), 32'd1);
      tx_en = 1'b0;
   endtask

   initial begin
      int         rd0;
      int         busy0;
      int         waited;
      bit         ok;
      bit         line_ok;
      logic [9:0] bits;

      vecs[0]  = '{data: 8'hA5, frame: 10'b1101001010};
      vecs[1]  = '{data: 8'h00, frame: 10'b1000000000};
      vecs[2]  = '{data: 8'hFF, frame: 10'b1111111110};
      vecs[3]  = '{data: 8'h3C, frame: 10'b1001111000};
      vecs[4]  = '{data: 8'h5A, frame: 10'b1010110100};
      vecs[5]  = '{data: 8'hC3, frame: 10'b1110000110};
      vecs[6]  = '{data: 8'h81, frame: 10'b1100000010};
      vecs[7]  = '{data: 8'h42, frame: 10'b1010000100};
      vecs[8]  = '{data: 8'h01, frame: 10'b1000000010};
      vecs[9]  = '{data: 8'h02, frame: 10'b1000000100};
      vecs[10] = '{data: 8'h03, frame: 10'b1000000110};
      vecs[11] = '{data: 8'h04, frame: 10'b1000001000};
      vecs[12] = '{data: 8'h05, frame: 10'b1000001010};
      vecs[13] = '{data: 8'h06, frame: 10'b1000001100};
      vecs[14] = '{data: 8'h07, frame: 10'b1000001110};

      rst      = 1'b1;
      fifo_rst = 1'b1;
      tx_en    = 1'b1;
      wr_en    = 1'b0;
      wr_data  = '0;
      repeat (3) step();
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
      rst      = 1'b0;
      fifo_rst = 1'b0;
      tx_en    = 1'b0;
      step();

      // Single byte with exact latency and busy length.
      push(vecs[0].data);
      rd0   = rd_pulses;
      busy0 = busy_cycles;
      tx_en = 1'b1;
      #1;
      check("single_pop_same_cycle", 32'(fifo_rd_en), 32'd1);
      step();
      check("single_load_tx", 32'(tx), 32'd1);
      check("single_load_busy", 32'(busy), 32'd1);
      check("single_load_no_pop", 32'(fifo_rd_en), 32'd0);
      step();
      check("single_tx_fall", 32'(tx), 32'd0);
      decode_frame(bits, waited, ok);
      check_frame("single", 0, bits, ok);
      wait_idle();
      check("single_busy_len", 32'(busy_cycles - busy0), 32'd101);
      check("single_pops", 32'(rd_pulses - rd0), 32'd1);
      check("single_empty", 32'(fifo_empty), 32'd1);
      check("single_tx_idle", 32'(tx), 32'd1);
      tx_en = 1'b0;

      run_burst("b2b", 1, 3, 1'b0);

      // tx_en gating: nothing moves while low; dropping it mid-frame stops after that frame.
      push(vecs[4].data);
      push(vecs[5].data);
      rd0     = rd_pulses;
      line_ok = 1'b1;
      repeat (50) begin
         step();
         if (tx !== 1'b1 || fifo_rd_en !== 1'b0) line_ok = 1'b0;
      end
      check("gate_idle_line", 32'(line_ok), 32'd1);
      check("gate_no_pop", 32'(rd_pulses - rd0), 32'd0);
      tx_en = 1'b1;
      fork
         decode_frame(bits, waited, ok);
         begin
            repeat (30) step();
            tx_en = 1'b0;
         end
      join
      check_frame("gate_frame1", 4, bits, ok);
      line_ok = 1'b1;
      repeat (200) begin
         step();
         if (tx !== 1'b1) line_ok = 1'b0;
      end
      check("gate_no_frame2", 32'(line_ok), 32'd1);
      check("gate_one_pop", 32'(rd_pulses - rd0), 32'd1);
      check("gate_fifo_left", 32'(fifo_count), 32'd1);
      check("gate_busy_low", 32'(busy), 32'd0);

      // Reset in the middle of data bit 4 of 0x81.
      fifo_rst = 1'b1;
      step();
      fifo_rst = 1'b0;
      push(vecs[6].data);
      push(vecs[7].data);
      tx_en  = 1'b1;
      waited = 0;
      while (tx !== 1'b0 && waited < 50) begin
         step();
         waited++;
      end
      check("rst_frame_start", 32'(tx), 32'd0);
      repeat (55) step();
      check("rst_bit4_low", 32'(tx), 32'd0);
      rst = 1'b1;
      step();
      check("rst_mid_tx", 32'(tx), 32'd1);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_rd_en", 32'(fifo_rd_en), 32'd0);
      rst = 1'b0;
      decode_frame(bits, waited, ok);
      check_frame("rst_next", 7, bits, ok);
      wait_idle();
      check("rst_empty", 32'(fifo_empty), 32'd1);

      // Empty FIFO with tx_en high.
      rd0     = rd_pulses;
      line_ok = 1'b1;
      repeat (200) begin
         step();
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) line_ok = 1'b0;
      end
      check("empty_idle_line", 32'(line_ok), 32'd1);
      check("empty_no_pop", 32'(rd_pulses - rd0), 32'd0);
      tx_en = 1'b0;

      run_burst("drain", 8, 7, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
